uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for a UART engine: arms the engine, queues received
// bytes in a small FIFO, and raises sticky overrun and idle-timeout flags.
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int TIMEOUT_BITS = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            sync_reset,
   input  logic                            enable,
   output logic                            start_rx,
   input  logic                            rx_ri,
   input  logic [DATA_WIDTH-1:0]           rx_sbuf,
   input  logic                            rd_en,
   output logic [DATA_WIDTH-1:0]           rd_data,
   output logic                            rd_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            empty,
   output logic                            full,
   output logic                            overrun,
   input  logic                            clr_flags,
   input  logic [TIMEOUT_BITS-1:0]         timeout_m1,
   output logic                            timeout_irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT} state_t;

   state_t                  state;
   logic                    push;
   logic                    pop;
   logic                    accept;
   logic                    irq_clear;
   logic                    irq_set;
   logic                    timeout_armed;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [CW-1:0]           count_nxt;
   logic [TIMEOUT_BITS-1:0] idle_cnt;
   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

   function automatic logic [TIMEOUT_BITS-1:0] sat_inc(
      input logic [TIMEOUT_BITS-1:0] v,
      input logic [TIMEOUT_BITS-1:0] lim
   );
      return (v >= lim) ? lim : v + TIMEOUT_BITS'(1);
   endfunction

   // A pop is honoured when data is present or arrives this cycle; a full
   // FIFO still accepts a byte when the host frees a slot in the same cycle.
   assign push   = (state == S_WAIT) && enable && rx_ri;
   assign pop    = rd_en && (!empty || push);
   assign accept = push && (!full || pop);
   assign empty  = (fifo_count == '0);
   assign full   = (fifo_count == CW'(FIFO_DEPTH));

   always_comb begin
      count_nxt = fifo_count;
      if (accept && !pop)
         count_nxt = fifo_count + CW'(1);
      else if (pop && !accept)
         count_nxt = fifo_count - CW'(1);
   end

   // The timeout fires once per burst: after a clear it stays quiet until
   // the next byte arrives, otherwise the saturated counter would re-fire it.
   assign irq_clear = clr_flags || push || (pop && (count_nxt == '0));
   assign irq_set   = timeout_armed && !empty && (idle_cnt == timeout_m1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         start_rx <= 1'b0;
      end else if (sync_reset) begin
         state    <= S_IDLE;
         start_rx <= 1'b0;
      end else begin
         start_rx <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state    <= S_ARM;
                  start_rx <= 1'b1;
               end
            end
            S_ARM: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (!enable) begin
                  state <= S_IDLE;
               end else if (rx_ri) begin
                  state    <= S_ARM;
                  start_rx <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= rx_sbuf;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         overrun       <= 1'b0;
         idle_cnt      <= '0;
         timeout_irq   <= 1'b0;
         timeout_armed <= 1'b0;
      end else if (sync_reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         overrun       <= 1'b0;
         idle_cnt      <= '0;
         timeout_irq   <= 1'b0;
         timeout_armed <= 1'b0;
      end else begin
         fifo_count <= count_nxt;
         rd_valid   <= pop;
         if (accept)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_data <= empty ? rx_sbuf : mem[rd_ptr];
         end

         if (push && !accept)
            overrun <= 1'b1;
         else if (clr_flags)
            overrun <= 1'b0;

         if (push || empty)
            idle_cnt <= '0;
         else
            idle_cnt <= sat_inc(idle_cnt, timeout_m1);

         if (irq_clear)
            timeout_irq <= 1'b0;
         else if (irq_set)
            timeout_irq <= 1'b1;

         if (push)
            timeout_armed <= 1'b1;
         else if (irq_set && !irq_clear)
            timeout_armed <= 1'b0;
      end
   end

endmodule
